// File: rtl/ds1302_pkg.sv
// Shared constants for the DS1302 snapshot layout and the ASCII time-line formatter.
package ds1302_pkg;

  localparam int SEC_LSB  = 48;
  localparam int MIN_LSB  = 40;
  localparam int HOUR_LSB = 32;
  localparam int DATE_LSB = 24;
  localparam int MON_LSB  = 16;
  localparam int WDAY_LSB = 8;
  localparam int YEAR_LSB = 0;

  localparam int LINE_LEN_CRLF = 23;
  localparam int LINE_LEN_LF   = 22;

  localparam logic [4:0] IDX_CENT_HI = 5'd0;
  localparam logic [4:0] IDX_CENT_LO = 5'd1;
  localparam logic [4:0] IDX_YEAR_HI = 5'd2;
  localparam logic [4:0] IDX_YEAR_LO = 5'd3;
  localparam logic [4:0] IDX_DASH0   = 5'd4;
  localparam logic [4:0] IDX_MON_HI  = 5'd5;
  localparam logic [4:0] IDX_MON_LO  = 5'd6;
  localparam logic [4:0] IDX_DASH1   = 5'd7;
  localparam logic [4:0] IDX_DATE_HI = 5'd8;
  localparam logic [4:0] IDX_DATE_LO = 5'd9;
  localparam logic [4:0] IDX_SPACE0  = 5'd10;
  localparam logic [4:0] IDX_WDAY    = 5'd11;
  localparam logic [4:0] IDX_SPACE1  = 5'd12;
  localparam logic [4:0] IDX_HOUR_HI = 5'd13;
  localparam logic [4:0] IDX_HOUR_LO = 5'd14;
  localparam logic [4:0] IDX_COLON0  = 5'd15;
  localparam logic [4:0] IDX_MIN_HI  = 5'd16;
  localparam logic [4:0] IDX_MIN_LO  = 5'd17;
  localparam logic [4:0] IDX_COLON1  = 5'd18;
  localparam logic [4:0] IDX_SEC_HI  = 5'd19;
  localparam logic [4:0] IDX_SEC_LO  = 5'd20;
  localparam logic [4:0] IDX_EOL0    = 5'd21;
  localparam logic [4:0] IDX_EOL1    = 5'd22;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_QM    = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic {ST_IDLE, ST_SEND} fmt_state_t;

  // Only the bits that survive masking are held; clock-halt and 12/24 bits never reach the line.
  typedef struct packed {
    logic [6:0] sec;
    logic [7:0] min;
    logic [5:0] hour;
    logic [7:0] date;
    logic [7:0] month;
    logic [2:0] wday;
    logic [7:0] year;
  } snap_t;

endpackage

// File: rtl/bcd_ascii.sv
// Combinational BCD nibble to ASCII digit; non-decimal nibbles become '?'.
module bcd_ascii
  import ds1302_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  assign asc = (nib > 4'd9) ? ASC_QM : (ASC_ZERO | {4'h0, nib});

endmodule

// File: rtl/ds1302_time_fmt.sv
// Streams one "CCYY-MM-DD W HH:MM:SS" + EOL line per accepted DS1302 snapshot over valid/ready.
//   state   | meaning
//   IDLE    | waiting for din_vld; outputs quiet
//   SEND    | presenting byte[idx], advancing on each handshake
module ds1302_time_fmt
  import ds1302_pkg::*;
#(
  parameter int CENTURY  = 20,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] din,
  input  logic        din_vld,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        overrun
);

  localparam logic [4:0] LAST_IDX = EOL_CRLF ? 5'(LINE_LEN_CRLF - 1) : 5'(LINE_LEN_LF - 1);
  localparam logic [3:0] CENT_HI  = 4'((CENTURY / 10) % 10);
  localparam logic [3:0] CENT_LO  = 4'(CENTURY % 10);

  fmt_state_t state, state_nx;
  logic [4:0] idx, idx_nx;
  snap_t      snap, din_snap;
  logic       load, adv, vld_nx, busy_nx, ovr_nx;
  logic [3:0] nib;
  logic [7:0] nib_asc, byte_nx;
  logic       unused_din_bits;

  assign din_snap = '{
    sec:   din[SEC_LSB +: 7],
    min:   din[MIN_LSB +: 8],
    hour:  din[HOUR_LSB +: 6],
    date:  din[DATE_LSB +: 8],
    month: din[MON_LSB +: 8],
    wday:  din[WDAY_LSB +: 3],
    year:  din[YEAR_LSB +: 8]
  };
  assign unused_din_bits = ^{din[SEC_LSB + 7], din[HOUR_LSB + 7 -: 2], din[WDAY_LSB + 7 -: 5]};

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    adv      = 1'b0;
    vld_nx   = tx_vld;
    busy_nx  = busy;
    ovr_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din_vld) begin
          load     = 1'b1;
          adv      = 1'b1;
          idx_nx   = '0;
          vld_nx   = 1'b1;
          busy_nx  = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        ovr_nx = din_vld;
        if (tx_vld && tx_rdy) begin
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            vld_nx   = 1'b0;
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + 5'd1;
            adv    = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Byte 0 is a constant, so indexing by idx_nx against the old snapshot is safe on load.
  always_comb begin
    nib = 4'h0;
    case (idx_nx)
      IDX_CENT_HI: nib = CENT_HI;
      IDX_CENT_LO: nib = CENT_LO;
      IDX_YEAR_HI: nib = snap.year[7:4];
      IDX_YEAR_LO: nib = snap.year[3:0];
      IDX_MON_HI:  nib = snap.month[7:4];
      IDX_MON_LO:  nib = snap.month[3:0];
      IDX_DATE_HI: nib = snap.date[7:4];
      IDX_DATE_LO: nib = snap.date[3:0];
      IDX_WDAY:    nib = {1'b0, snap.wday};
      IDX_HOUR_HI: nib = {2'b00, snap.hour[5:4]};
      IDX_HOUR_LO: nib = snap.hour[3:0];
      IDX_MIN_HI:  nib = snap.min[7:4];
      IDX_MIN_LO:  nib = snap.min[3:0];
      IDX_SEC_HI:  nib = {1'b0, snap.sec[6:4]};
      IDX_SEC_LO:  nib = snap.sec[3:0];
      default:     nib = 4'h0;
    endcase
  end

  bcd_ascii u_bcd_ascii (
    .nib (nib),
    .asc (nib_asc)
  );

  always_comb begin
    byte_nx = nib_asc;
    case (idx_nx)
      IDX_DASH0, IDX_DASH1:   byte_nx = ASC_DASH;
      IDX_SPACE0, IDX_SPACE1: byte_nx = ASC_SPACE;
      IDX_COLON0, IDX_COLON1: byte_nx = ASC_COLON;
      IDX_WDAY:               byte_nx = (snap.wday == 3'd0) ? ASC_QM : nib_asc;
      IDX_EOL0:               byte_nx = EOL_CRLF ? ASC_CR : ASC_LF;
      IDX_EOL1:               byte_nx = ASC_LF;
      default:                byte_nx = nib_asc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      snap    <= '0;
      tx_data <= 8'h00;
      tx_vld  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      if (load) snap <= din_snap;
      if (adv) tx_data <= byte_nx;
      tx_vld  <= vld_nx;
      busy    <= busy_nx;
      overrun <= ovr_nx;
    end
  end

endmodule

// File: doc/ds1302_time_fmt.md
# ds1302_time_fmt

Formatter between the DS1302 interface read-back and the UART byte transmitter. On each validated 56-bit BCD time snapshot it emits one ASCII line, `20YY-MM-DD W HH:MM:SS` plus EOL, one byte at a time over a valid/ready byte handshake. It holds the snapshot for the duration of the line and flags snapshots that arrive while a line is still in progress.

## Interface
- `CENTURY`, default 20: two decimal digits sent as the first two characters.
- `EOL_CRLF`, default 1: 1 = line ends `\r\n` (23 bytes); 0 = `\n` only (22 bytes).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `din`  in  56: BCD snapshot. [55:48] sec, [47:40] min, [39:32] hour, [31:24] date, [23:16] month, [15:8] weekday, [7:0] year.
- `din_vld`  in  1: single-cycle strobe qualifying `din`.
- `tx_data`  out  8: ASCII byte.
- `tx_vld`  out  1: `tx_data` valid.
- `tx_rdy`  in  1: sink accepts the byte when `tx_vld && tx_rdy`.
- `busy`  out  1: a line is in progress.
- `overrun`  out  1: one-cycle pulse when a `din_vld` is dropped.

## Operation
- FSM states:
  - IDLE:
    - On `din_vld`, latch `din` into the snapshot register and set the index to 0.
    - Go to SEND.
  - SEND:
    - Present byte[idx].
    - On handshake, idx increments.
    - On the handshake of the last byte, go to IDLE.
- Masking before conversion:
  - sec[7] (clock-halt) is forced to 0.
  - hour[7:6] (12/24 mode bits) are forced to 0; 24-hour mode is mandatory.
  - Weekday uses bits [10:8] only.
- Byte order (idx):
  - 0–1: CENTURY digits.
  - 2–3: year hi/lo nibble.
  - 4: `-`.
  - 5–6: month.
  - 7: `-`.
  - 8–9: date.
  - 10: space.
  - 11: weekday.
  - 12: space.
  - 13–14: hour.
  - 15: `:`.
  - 16–17: min.
  - 18: `:`.
  - 19–20: sec.
  - 21: 0x0D, then 22: 0x0A (EOL_CRLF=1); or 21: 0x0A (EOL_CRLF=0).
- Nibble conversion: 0–9 → 0x30+n; 10–15 → `?` (0x3F).
- Weekday conversion: 1–7 → 0x31–0x37; 0 → `?`.
- Overrun:
  - `din_vld` while `busy`=1 is ignored and pulses `overrun` the next cycle.
  - This includes the cycle of the final handshake; the snapshot and stream are unaffected.
- Snapshot content changes only on an accepted `din_vld` in IDLE.

## Timing
- Reset values: `tx_data`=0x00, `tx_vld`=0, `busy`=0, `overrun`=0, idx=0, state IDLE, snapshot=0.
- All outputs are registered.
- Start latency: `din_vld` in cycle N → `busy`=1 and `tx_vld`=1 with byte 0 in cycle N+1.
- Valid/ready rules:
  - `tx_vld` never drops without a handshake.
  - `tx_data` is stable while `tx_vld && !tx_rdy`.
  - No combinational path from `tx_rdy` to `tx_vld` or `tx_data`.
- Throughput: one byte per cycle with `tx_rdy` held high, so a full line takes 23 cycles (22 with EOL_CRLF=0).
- Last-byte handshake in cycle M → `tx_vld`=0 and `busy`=0 in M+1. The earliest next accepted `din_vld` is in M+1.
- Reset mid-line: outputs return to reset values immediately; the partial line is abandoned. After release, the next `din_vld` starts at byte 0.

## Structure
- Shared package `ds1302_pkg` holds:
  - field offset localparams for the 56-bit snapshot layout, shared with the interface and controller;
  - byte-index constants and line length per EOL mode;
  - ASCII constants (`-`, `:`, space, `?`, CR, LF).
- One sub-module, `bcd_ascii`: purely combinational 4-bit BCD → 8-bit ASCII with `?` substitution. It is instantiated once on a mux-selected nibble.
- Top holds the FSM, index counter, snapshot register, byte mux and output registers.

## Test plan
- Nominal line:
  - Stimulus: sec 0x45, min 0x30, hour 0x13, date 0x07, month 0x11, weekday 0x03, year 0x24; `tx_rdy`=1.
  - Response: `2024-11-07 3 13:30:45\r\n`, 23 bytes on 23 consecutive cycles; `busy` falls one cycle after the last byte.
- Masking:
  - Stimulus: sec 0x85, hour 0xD3.
  - Response: seconds `05`, hour `13`.
- Backpressure:
  - Stimulus: pseudo-random `tx_rdy` at 50% duty.
  - Response: identical 23-byte sequence; `tx_data` never changes while stalled.
- Invalid BCD:
  - Stimulus: min 0x5A, weekday 0x00.
  - Response: minutes `5?`, weekday `?`.
- Overrun:
  - Stimulus: `din_vld` at byte 5, and again in the last-handshake cycle.
  - Response: two `overrun` pulses; line content unchanged.
- Reset and EOL mode:
  - Stimulus: `rst` pulsed after byte 10.
  - Response: `tx_vld`=0 at once; the next snapshot restarts at `2`.
  - Stimulus: EOL_CRLF=0.
  - Response: 22 bytes ending 0x0A.
